// File: rtl/rotseq_pkg.sv
// Shared types and widths for the rotate_seq16 rotation sequencer.
package rotseq_pkg;

  localparam int DATA_W = 16;
  localparam int AMT_W  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/rotate_seq16_if.sv
// Command and result handshake bundle for rotate_seq16; slave is the sequencer side.
interface rotate_seq16_if #(
  parameter int CNT_W = 8
);

  logic                          cmd_valid;
  logic                          cmd_ready;
  logic [rotseq_pkg::DATA_W-1:0] cmd_data;
  logic [rotseq_pkg::AMT_W-1:0]  cmd_amt;
  logic                          cmd_lr;
  logic [CNT_W-1:0]              cmd_count;

  logic                          out_valid;
  logic                          out_ready;
  logic [rotseq_pkg::DATA_W-1:0] out_data;

  modport master (
    output cmd_valid, cmd_data, cmd_amt, cmd_lr, cmd_count, out_ready,
    input  cmd_ready, out_valid, out_data
  );

  modport slave (
    input  cmd_valid, cmd_data, cmd_amt, cmd_lr, cmd_count, out_ready,
    output cmd_ready, out_valid, out_data
  );

endinterface

// File: rtl/bshifter16_r.sv
// Combinational 16-bit rotator; lr=1 rotates left, lr=0 rotates right.
module bshifter16_r (
  input  logic [15:0] a,
  input  logic [3:0]  amt,
  input  logic        lr,
  output logic [15:0] y
);

  logic [31:0] dbl;
  logic [31:0] shl;
  logic [31:0] shr;

  // Shifting a doubled copy turns each rotation into a plain shift plus a slice.
  always_comb begin
    dbl = {a, a};
    shl = dbl << amt;
    shr = dbl >> amt;
    y   = lr ? shl[31:16] : shr[15:0];
  end

endmodule

// File: rtl/rotate_seq16.sv
// Command-driven rotation sequencer: latches one pattern and emits a burst of rotated results.
// Optional step spacing timer is enabled by defining ROTSEQ_STEP_TIMER_EN.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high unless abort
// RUN   | issuing results into the output register
// DRAIN | last result (if any) waiting to be taken; done pulses on exit
module rotate_seq16
  import rotseq_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int PRESCALE_W = 24
) (
  input  logic                  clk,
  input  logic                  rst_n,
  rotate_seq16_if.slave         bus,
  input  logic [PRESCALE_W-1:0] step_div,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done
);

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   cur_q;
  logic [AMT_W-1:0]    amt_q;
  logic                lr_q;
  logic [CNT_W-1:0]    rem_q;
  logic                out_valid_q;
  logic [DATA_W-1:0]   out_data_q;
  logic                abort_q;
  logic [DATA_W-1:0]   rot;

  logic                accept;
  logic                abort_hit;
  logic                step_ok;
  logic                slot_free;
  logic                issue;
  logic                drain_exit;

  bshifter16_r u_rot (
    .a   (cur_q),
    .amt (amt_q),
    .lr  (lr_q),
    .y   (rot)
  );

  assign bus.cmd_ready = (state_q == IDLE) && !abort;
  assign accept        = bus.cmd_valid && bus.cmd_ready;
  assign abort_hit     = abort && (state_q != IDLE);
  assign slot_free     = (!out_valid_q || bus.out_ready) && step_ok && (rem_q != '0);

`ifdef ROTSEQ_STEP_TIMER_EN
  logic [PRESCALE_W-1:0] step_q;
  logic [PRESCALE_W-1:0] timer_q;

  assign step_ok = (timer_q == '0);

  // Timer keeps running under backpressure and parks at zero until the next issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_q  <= '0;
      timer_q <= '0;
    end else if (accept) begin
      step_q  <= step_div;
      timer_q <= step_div;
    end else if (issue) begin
      timer_q <= step_q;
    end else if (timer_q != '0) begin
      timer_q <= timer_q - PRESCALE_W'(1);
    end
  end
`else
  logic unused_step_div;

  assign step_ok         = 1'b1;
  assign unused_step_div = ^step_div;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    issue      = 1'b0;
    drain_exit = 1'b0;
    if (abort_hit) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) state_d = (bus.cmd_count == '0) ? DRAIN : RUN;
        end
        RUN: begin
          if (slot_free) begin
            issue = 1'b1;
            if (rem_q == CNT_W'(1)) state_d = DRAIN;
          end
        end
        DRAIN: begin
          if (!out_valid_q || bus.out_ready) begin
            drain_exit = 1'b1;
            state_d    = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_q <= '0;
      amt_q <= '0;
      lr_q  <= 1'b0;
      rem_q <= '0;
    end else if (accept) begin
      cur_q <= bus.cmd_data;
      amt_q <= bus.cmd_amt;
      lr_q  <= bus.cmd_lr;
      rem_q <= bus.cmd_count;
    end else if (abort_hit) begin
      rem_q <= '0;
    end else if (issue) begin
      cur_q <= rot;
      rem_q <= rem_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      abort_q     <= 1'b0;
    end else begin
      abort_q <= abort_hit;
      if (abort_hit) begin
        out_valid_q <= 1'b0;
      end else if (issue) begin
        out_valid_q <= 1'b1;
        out_data_q  <= rot;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign busy          = (state_q != IDLE);
  assign done          = drain_exit || abort_q;

endmodule

// File: tb/tb_rotate_seq16.sv
// Directed self-checking bench for rotate_seq16 with a queue-based result model.
module tb_rotate_seq16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [23:0] step_div;
  logic        abort;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int done_cnt = 0;
  int valid_cnt = 0;
  logic        stall_prev = 1'b0;
  logic [15:0] stall_data = '0;
  logic [15:0] exp_q[$];
  int          hs_cyc[$];

  rotate_seq16_if #(.CNT_W(8)) bus ();

  rotate_seq16 #(.CNT_W(8), .PRESCALE_W(24)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .step_div (step_div),
    .abort    (abort),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] rot_model(input logic [15:0] d, input int s, input logic lr);
    int sh;
    logic [31:0] w;
    sh = s % 16;
    if (sh == 0) return d;
    w = {16'h0, d};
    if (lr) w = (w << sh) | (w >> (16 - sh));
    else    w = (w >> sh) | (w << (16 - sh));
    return w[15:0];
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Single compare process: every taken result must match the head of the model queue,
  // and a stalled result must hold its value.
  always @(negedge clk) begin
    if (rst_n) begin
      if (stall_prev) begin
        checks++;
        if (!(bus.out_valid && bus.out_data == stall_data)) begin
          errors++;
          $display("FAIL hold: valid=%0b data=0x%0h, expected valid=1 data=0x%0h", bus.out_valid, bus.out_data, stall_data);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL result: got unexpected 0x%0h, expected no result", bus.out_data);
        end else begin
          logic [15:0] e;
          e = exp_q.pop_front();
          if (bus.out_data !== e) begin
            errors++;
            $display("FAIL result: got 0x%0h, expected 0x%0h", bus.out_data, e);
          end
        end
        hs_cyc.push_back(cyc);
      end
      if (bus.out_valid) valid_cnt++;
      if (done) done_cnt++;
      if (bus.cmd_valid && bus.cmd_ready) acc_cyc = cyc;
      stall_prev = bus.out_valid && !bus.out_ready;
      stall_data = bus.out_data;
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic send(input logic [15:0] d, input logic [3:0] a, input logic lr, input int cnt, input int sd);
    int n;
    for (int k = 1; k <= cnt; k++) exp_q.push_back(rot_model(d, k * a, lr));
    bus.cmd_data  = d;
    bus.cmd_amt   = a;
    bus.cmd_lr    = lr;
    bus.cmd_count = 8'(cnt);
    step_div      = 24'(sd);
    bus.cmd_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.cmd_ready && n < 50);
    check("accept_in_time", {31'b0, bus.cmd_ready}, 32'd1);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = 16'hDEAD;
    bus.cmd_amt   = 4'hF;
    bus.cmd_lr    = ~lr;
    bus.cmd_count = 8'hFF;
    step_div      = 24'd7;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || bus.out_valid) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("idle_in_time", {31'b0, busy | bus.out_valid}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_hs(input int num);
    int n;
    n = 0;
    while (hs_cyc.size() < num && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("results_in_time", {31'b0, hs_cyc.size() >= num}, 32'd1);
  endtask

  initial begin
    int d0, v0, n;
    rst_n         = 1'b0;
    abort         = 1'b0;
    step_div      = '0;
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = '0;
    bus.cmd_amt   = '0;
    bus.cmd_lr    = 1'b0;
    bus.cmd_count = '0;
    bus.out_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("rst_cmd_ready", {31'b0, bus.cmd_ready}, 32'd1);
    check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("rst_out_data", {16'b0, bus.out_data}, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    check("model_rol1", {16'b0, rot_model(16'h0001, 1, 1'b1)}, 32'h0002);
    check("model_ror4", {16'b0, rot_model(16'h8001, 4, 1'b0)}, 32'h1800);
    check("model_rol12", {16'b0, rot_model(16'h8001, 12, 1'b1)}, 32'h1800);
    check("model_rol16", {16'b0, rot_model(16'h00FF, 16, 1'b1)}, 32'h00FF);

    // Test 1: left by 1, four results back to back
    hs_cyc.delete();
    d0 = done_cnt;
    send(16'h0001, 4'd1, 1'b1, 4, 0);
    wait_idle();
    check("t1_count", hs_cyc.size(), 32'd4);
    if (hs_cyc.size() == 4) begin
      check("t1_latency", hs_cyc[0] - acc_cyc, 32'd2);
      for (int i = 1; i < 4; i++) check("t1_spacing", hs_cyc[i] - hs_cyc[i-1], 32'd1);
    end
    check("t1_done", done_cnt - d0, 32'd1);
    check("t1_queue", exp_q.size(), 32'd0);

    // Test 2: right then left by 4
    d0 = done_cnt;
    send(16'h8001, 4'd4, 1'b0, 3, 0);
    wait_idle();
    send(16'h8001, 4'd4, 1'b1, 3, 0);
    wait_idle();
    check("t2_done", done_cnt - d0, 32'd2);
    check("t2_queue", exp_q.size(), 32'd0);

    // Test 3: backpressure holds the first result
    hs_cyc.delete();
    bus.out_ready = 1'b0;
    send(16'h00FF, 4'd8, 1'b1, 2, 0);
    repeat (6) @(posedge clk);
    #1;
    check("t3_stalled_data", {16'b0, bus.out_data}, 32'hFF00);
    bus.out_ready = 1'b1;
    wait_idle();
    check("t3_count", hs_cyc.size(), 32'd2);
    check("t3_queue", exp_q.size(), 32'd0);

    // Test 4: zero count, then zero amount
    d0 = done_cnt;
    v0 = valid_cnt;
    send(16'h00FF, 4'd3, 1'b1, 0, 0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.cmd_ready && n < 5);
    check("t4_ready_within_2", {31'b0, n <= 2}, 32'd1);
    @(posedge clk);
    #1;
    check("t4_done", done_cnt - d0, 32'd1);
    check("t4_no_valid", valid_cnt - v0, 32'd0);
    hs_cyc.delete();
    send(16'h00FF, 4'd0, 1'b0, 3, 0);
    wait_idle();
    check("t4_amt0_count", hs_cyc.size(), 32'd3);

    // Test 5: abort mid-burst, then a fresh command
    hs_cyc.delete();
    d0 = done_cnt;
    send(16'h0001, 4'd1, 1'b1, 10, 0);
    wait_hs(2);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    @(negedge clk);
    check("t5_valid_cleared", {31'b0, bus.out_valid}, 32'd0);
    check("t5_done_pulse", {31'b0, done}, 32'd1);
    check("t5_idle", {31'b0, busy}, 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    check("t5_done_once", done_cnt - d0, 32'd1);
    hs_cyc.delete();
    send(16'h0001, 4'd1, 1'b1, 1, 0);
    wait_idle();
    check("t5_next_count", hs_cyc.size(), 32'd1);
    check("t5_queue", exp_q.size(), 32'd0);

`ifdef ROTSEQ_STEP_TIMER_EN
    // Test 6: results spaced step_div+1 cycles apart
    hs_cyc.delete();
    v0 = valid_cnt;
    send(16'h0001, 4'd1, 1'b1, 3, 3);
    wait_idle();
    check("t6_count", hs_cyc.size(), 32'd3);
    if (hs_cyc.size() == 3) begin
      check("t6_first", hs_cyc[0] - acc_cyc, 32'd5);
      for (int i = 1; i < 3; i++) check("t6_spacing", hs_cyc[i] - hs_cyc[i-1], 32'd4);
    end
    check("t6_valid_cycles", valid_cnt - v0, 32'd3);
`endif

    // Asynchronous reset mid-burst: outputs drop immediately, no done
    hs_cyc.delete();
    send(16'h0001, 4'd1, 1'b1, 10, 1);
    wait_hs(2);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("rst_mid_out_data", {16'b0, bus.out_data}, 32'h0);
    check("rst_mid_busy", {31'b0, busy}, 32'd0);
    check("rst_mid_done", {31'b0, done}, 32'd0);
    check("rst_mid_cmd_ready", {31'b0, bus.cmd_ready}, 32'd1);
    d0 = done_cnt;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    check("rst_mid_no_done", done_cnt - d0, 32'd0);
    check("rst_mid_idle", {31'b0, busy | bus.out_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion before 200000");
    $fatal(1, "watchdog");
  end

endmodule
